// File: rtl/systolic_n_body_pkg.sv
// Shared definitions for the systolic n-body pipeline: fixed-point type,
// accumulate/drain state encoding and the output saturation helpers.
package systolic_n_body_pkg;

    localparam int W        = 32;
    localparam int FRAC     = 16;
    localparam int SAT_IN_W = 2 * W;

    typedef logic signed [W-1:0] fixed_t;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DRAIN = 1'b1
    } state_t;

    localparam logic signed [SAT_IN_W-1:0] FIX_MAX_EXT = {{W{1'b0}}, 1'b0, {(W-1){1'b1}}};
    localparam logic signed [SAT_IN_W-1:0] FIX_MIN_EXT = {{W{1'b1}}, 1'b1, {(W-1){1'b0}}};

    // True when a wide value does not fit in fixed_t and would be clamped.
    function automatic logic sat_hit(input logic signed [SAT_IN_W-1:0] x);
        return (x > FIX_MAX_EXT) || (x < FIX_MIN_EXT);
    endfunction

    // Clamp a sign-extended wide value into fixed_t.
    function automatic fixed_t sat_fixed(input logic signed [SAT_IN_W-1:0] x);
        fixed_t r;
        if (x > FIX_MAX_EXT) begin
            r = {1'b0, {(W-1){1'b1}}};
        end else if (x < FIX_MIN_EXT) begin
            r = {1'b1, {(W-1){1'b0}}};
        end else begin
            r = fixed_t'(x[W-1:0]);
        end
        return r;
    endfunction

endpackage

// File: rtl/systolic_n_body_accel_accum_if.sv
// Handshake bundle between the array bottom edge, the accumulator and the
// integration stage.
interface systolic_n_body_accel_accum_if #(
    parameter int N_BODIES = 2,
    parameter int W        = 32
);
    localparam int IW = (N_BODIES > 1) ? $clog2(N_BODIES) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [N_BODIES*W-1:0] in_p_down;
    logic                  out_valid;
    logic                  out_ready;
    logic [W-1:0]          out_a_t;
    logic [IW-1:0]         out_idx;
    logic                  out_sat;
    logic                  step_done;

    modport slave (
        input  in_valid, in_p_down, out_ready,
        output in_ready, out_valid, out_a_t, out_idx, out_sat, step_done
    );

    modport master (
        output in_valid, in_p_down, out_ready,
        input  in_ready, out_valid, out_a_t, out_idx, out_sat, step_done
    );
endinterface

// File: rtl/systolic_n_body_accel_accum_acc_lane.sv
// One column accumulator: wide enough that summing a step never wraps.
// Exposes the saturated form of the value it will hold after this cycle so
// the top can register it straight into the output word.
module systolic_n_body_acc_lane
    import systolic_n_body_pkg::*;
#(
    parameter int ACC_W = W + 2
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   add,
    input  logic   clr,
    input  fixed_t din,
    output fixed_t sat_nxt,
    output logic   sat_hit_nxt
);

    logic signed [ACC_W-1:0]    acc_r;
    logic signed [ACC_W-1:0]    acc_nxt_s;
    logic signed [SAT_IN_W-1:0] acc_ext_s;

    // Next accumulator value: clear wins, otherwise add the sign-extended column.
    always_comb begin
        acc_nxt_s = acc_r;
        if (clr) begin
            acc_nxt_s = {ACC_W{1'b0}};
        end else if (add) begin
            acc_nxt_s = acc_r + {{(ACC_W-W){din[W-1]}}, din};
        end else begin
            acc_nxt_s = acc_r;
        end
        acc_ext_s   = {{(SAT_IN_W-ACC_W){acc_nxt_s[ACC_W-1]}}, acc_nxt_s};
        sat_nxt     = sat_fixed(acc_ext_s);
        sat_hit_nxt = sat_hit(acc_ext_s);
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r <= {ACC_W{1'b0}};
        end else begin
            acc_r <= acc_nxt_s;
        end
    end

endmodule

// File: rtl/systolic_n_body_accel_accum.sv
// Accumulates N_TILES beats of per-column partial accelerations, then drains
// one saturated result per body in index order over a valid/ready handshake.
module systolic_n_body_accel_accum
    import systolic_n_body_pkg::*;
#(
    parameter int N_BODIES = 2,
    parameter int N_TILES  = 4,
    parameter int W        = systolic_n_body_pkg::W,
    parameter int FRAC     = systolic_n_body_pkg::FRAC
) (
    input logic clk,
    input logic reset,
    systolic_n_body_accel_accum_if.slave bus
);

    localparam int ACC_W = W + $clog2(N_TILES);
    localparam int IW    = (N_BODIES > 1) ? $clog2(N_BODIES) : 1;
    localparam int TW    = (N_TILES > 1) ? $clog2(N_TILES) : 1;

    localparam logic [IW-1:0] LAST_IDX  = IW'(N_BODIES - 1);
    localparam logic [TW-1:0] LAST_TILE = TW'(N_TILES - 1);

    if (FRAC >= W || N_BODIES < 1 || N_TILES < 1) begin : g_param_check
        $error("systolic_n_body_accel_accum: illegal parameter combination");
    end

    state_t        state_r;
    logic [TW-1:0] tile_cnt_r;
    logic [IW-1:0] out_idx_r;
    fixed_t        out_a_t_r;
    logic          in_ready_r;
    logic          out_valid_r;
    logic          out_sat_r;
    logic          step_done_r;

    logic          accept_s;
    logic          clear_s;
    logic [IW-1:0] idx_inc_s;
    fixed_t        lane_sat_s [N_BODIES];
    logic [N_BODIES-1:0] lane_hit_s;

    // Handshake strobes shared by the lanes and the control register block.
    always_comb begin
        accept_s  = 1'b0;
        clear_s   = 1'b0;
        idx_inc_s = out_idx_r + IW'(1'b1);
        if (state_r == ACCUM) begin
            accept_s = bus.in_valid;
        end else begin
            clear_s = bus.out_ready && (out_idx_r == LAST_IDX);
        end
    end

    for (genvar c = 0; c < N_BODIES; c++) begin : g_lane
        systolic_n_body_acc_lane #(.ACC_W(ACC_W)) u_lane (
            .clk         (clk),
            .reset       (reset),
            .add         (accept_s),
            .clr         (clear_s),
            .din         (fixed_t'(bus.in_p_down[c*W +: W])),
            .sat_nxt     (lane_sat_s[c]),
            .sat_hit_nxt (lane_hit_s[c])
        );
    end

    // Step FSM with registered handshake, data and flag outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ACCUM;
            tile_cnt_r  <= {TW{1'b0}};
            out_idx_r   <= {IW{1'b0}};
            out_a_t_r   <= {W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_sat_r   <= 1'b0;
            step_done_r <= 1'b0;
        end else begin
            step_done_r <= 1'b0;
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        tile_cnt_r <= tile_cnt_r + TW'(1'b1);
                        if (tile_cnt_r == LAST_TILE) begin
                            // The first presented word is body 0; its clamp
                            // status is folded into the freshly cleared flag.
                            state_r     <= DRAIN;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            out_idx_r   <= {IW{1'b0}};
                            out_a_t_r   <= lane_sat_s[0];
                            out_sat_r   <= ((tile_cnt_r == {TW{1'b0}}) ? 1'b0 : out_sat_r)
                                           | lane_hit_s[0];
                        end else if (tile_cnt_r == {TW{1'b0}}) begin
                            out_sat_r <= 1'b0;
                        end else begin
                            out_sat_r <= out_sat_r;
                        end
                    end else begin
                        tile_cnt_r <= tile_cnt_r;
                    end
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (out_idx_r == LAST_IDX) begin
                            state_r     <= ACCUM;
                            tile_cnt_r  <= {TW{1'b0}};
                            out_idx_r   <= {IW{1'b0}};
                            out_a_t_r   <= {W{1'b0}};
                            in_ready_r  <= 1'b1;
                            out_valid_r <= 1'b0;
                            step_done_r <= 1'b1;
                        end else begin
                            out_idx_r <= idx_inc_s;
                            out_a_t_r <= lane_sat_s[idx_inc_s];
                            out_sat_r <= out_sat_r | lane_hit_s[idx_inc_s];
                        end
                    end else begin
                        out_idx_r <= out_idx_r;
                    end
                end
                default: begin
                    state_r     <= ACCUM;
                    tile_cnt_r  <= {TW{1'b0}};
                    out_idx_r   <= {IW{1'b0}};
                    out_a_t_r   <= {W{1'b0}};
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_a_t   = out_a_t_r;
    assign bus.out_idx   = out_idx_r;
    assign bus.out_sat   = out_sat_r;
    assign bus.step_done = step_done_r;

endmodule

// File: tb/tb_systolic_n_body_accel_accum.sv
// Scoreboard bench for the n-body acceleration accumulator (defaults:
// 2 bodies, 4 tiles, Q16.16).
module tb_systolic_n_body_accel_accum;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    systolic_n_body_accel_accum_if #(.N_BODIES(2), .W(32)) bus ();

    systolic_n_body_accel_accum dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [0:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t   sb[$];
    longint acc_m[2];
    logic   exp_sat;
    int     errors = 0;
    int     checks = 0;
    int     cycle_cnt = 0;

    // Free-running cycle counter used to measure step period.
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    function automatic logic [31:0] model_sat(input longint v);
        if (v > 64'sh0000_0000_7FFF_FFFF) return 32'h7FFF_FFFF;
        else if (v < -64'sh0000_0000_8000_0000) return 32'h8000_0000;
        else return v[31:0];
    endfunction

    // Present one beat for one cycle and fold it into the reference sums.
    task automatic beat(input logic [31:0] c0, input logic [31:0] c1);
        bus.in_valid  = 1'b1;
        bus.in_p_down = {c1, c0};
        acc_m[0] = acc_m[0] + $signed(c0);
        acc_m[1] = acc_m[1] + $signed(c1);
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_p_down = {64{1'b0}};
    endtask

    // Turn the reference sums into expected drain words.
    task automatic close_step();
        exp_t e;
        exp_sat = 1'b0;
        for (int c = 0; c < 2; c++) begin
            e.idx  = 1'(c);
            e.data = model_sat(acc_m[c]);
            if (acc_m[c] > 64'sh7FFF_FFFF || acc_m[c] < -64'sh8000_0000) exp_sat = 1'b1;
            sb.push_back(e);
            acc_m[c] = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_p_down = {64{1'b0}}; bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_a_t !== 32'h0) begin errors++; $display("FAIL reset_out_a_t: got %h want 0", bus.out_a_t); end
        checks++; if (bus.out_idx !== 1'b0) begin errors++; $display("FAIL reset_out_idx: got %0d want 0", bus.out_idx); end
        checks++; if (bus.out_sat !== 1'b0 || bus.step_done !== 1'b0) begin errors++; $display("FAIL reset_flags: got sat=%b done=%b want 0 0", bus.out_sat, bus.step_done); end
    endtask

    task automatic test_basic();
        int cyc, first_v; exp_t e;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (4) beat(32'h0001_0000, 32'hFFFF_8000);
        close_step();
        cyc = 0; first_v = -1;
        while (sb.size() != 0 && cyc < 20) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (first_v < 0) first_v = cyc;
                e = sb.pop_front(); checks++;
                if (bus.out_a_t !== e.data || bus.out_idx !== e.idx) begin errors++; $display("FAIL basic_data: got idx=%0d a_t=%h want idx=%0d a_t=%h", bus.out_idx, bus.out_a_t, e.idx, e.data); end
            end
            @(posedge clk); #1; cyc++;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL basic_timeout: %0d results left want 0", sb.size()); sb.delete(); end
        checks++; if (first_v != 0 || cyc != 2) begin errors++; $display("FAIL basic_timing: first valid at %0d drain cycles %0d want 0 2", first_v, cyc); end
        @(negedge clk);
        checks++; if (bus.step_done !== 1'b1 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_step_done: got done=%b in_ready=%b want 1 1", bus.step_done, bus.in_ready); end
        checks++; if (bus.out_sat !== exp_sat) begin errors++; $display("FAIL basic_sat: got %b want %b", bus.out_sat, exp_sat); end
        @(negedge clk);
        checks++; if (bus.step_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got %b want 0", bus.step_done); end
    endtask

    task automatic test_backpressure();
        int cyc; exp_t e;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (4) beat(32'h0002_0000, 32'h0001_0000);
        close_step();
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_p_down = {32'h1234_0000, 32'h0777_0000};
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 1'b0 || bus.out_a_t !== sb[0].data || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold: cyc %0d got v=%b idx=%0d a_t=%h rdy=%b want 1 0 %h 0", i, bus.out_valid, bus.out_idx, bus.out_a_t, bus.in_ready, sb[0].data);
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                e = sb.pop_front(); checks++;
                if (bus.out_a_t !== e.data || bus.out_idx !== e.idx) begin errors++; $display("FAIL bp_data: got idx=%0d a_t=%h want idx=%0d a_t=%h", bus.out_idx, bus.out_a_t, e.idx, e.data); end
            end
            @(posedge clk); #1; cyc++;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_timeout: %0d results left want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_saturation();
        int cyc; exp_t e;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (4) beat(32'h7000_0000, 32'h9000_0000);
        close_step();
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                e = sb.pop_front(); checks++;
                if (bus.out_a_t !== e.data || bus.out_idx !== e.idx) begin errors++; $display("FAIL sat_data: got idx=%0d a_t=%h want idx=%0d a_t=%h", bus.out_idx, bus.out_a_t, e.idx, e.data); end
            end
            @(posedge clk); #1; cyc++;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sat_timeout: %0d results left want 0", sb.size()); sb.delete(); end
        checks++; if (bus.out_sat !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b want 1", bus.out_sat); end
        beat(32'h0000_1000, 32'h0000_2000);
        @(negedge clk);
        checks++; if (bus.out_sat !== 1'b0) begin errors++; $display("FAIL sat_clear: got %b want 0", bus.out_sat); end
        @(posedge clk); #1;
        repeat (3) beat(32'h0000_1000, 32'h0000_2000);
        close_step();
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                e = sb.pop_front(); checks++;
                if (bus.out_a_t !== e.data || bus.out_idx !== e.idx) begin errors++; $display("FAIL sat_small_data: got idx=%0d a_t=%h want idx=%0d a_t=%h", bus.out_idx, bus.out_a_t, e.idx, e.data); end
            end
            @(posedge clk); #1; cyc++;
        end
        checks++; if (sb.size() != 0 || bus.out_sat !== 1'b0) begin errors++; $display("FAIL sat_small: left=%0d sat=%b want 0 0", sb.size(), bus.out_sat); sb.delete(); end
    endtask

    task automatic test_gapped();
        int cyc, first_v; exp_t e;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 1) beat(32'h0000_4000, 32'h0000_4000);
            else begin @(posedge clk); #1; end
        end
        close_step();
        cyc = 0; first_v = -1;
        while (sb.size() != 0 && cyc < 20) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                if (first_v < 0) first_v = cyc;
                e = sb.pop_front(); checks++;
                if (bus.out_a_t !== e.data || bus.out_idx !== e.idx) begin errors++; $display("FAIL gap_data: got idx=%0d a_t=%h want idx=%0d a_t=%h", bus.out_idx, bus.out_a_t, e.idx, e.data); end
            end
            @(posedge clk); #1; cyc++;
        end
        checks++; if (sb.size() != 0 || first_v != 0) begin errors++; $display("FAIL gap_timing: left=%0d first valid at %0d want 0 0", sb.size(), first_v); sb.delete(); end
    endtask

    task automatic test_reset_mid();
        int cyc, dones; exp_t e;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        repeat (2) beat(32'h0005_0000, 32'h0005_0000);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_a_t !== 32'h0 || bus.step_done !== 1'b0) begin errors++; $display("FAIL rst_accum: got rdy=%b v=%b a_t=%h done=%b want 1 0 0 0", bus.in_ready, bus.out_valid, bus.out_a_t, bus.step_done); end
        @(posedge clk); #1 reset = 1'b0;
        acc_m[0] = 0; acc_m[1] = 0;
        repeat (4) beat(32'h0003_0000, 32'h0003_0000);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_idx !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_drain: got v=%b idx=%0d rdy=%b want 0 0 1", bus.out_valid, bus.out_idx, bus.in_ready); end
        @(posedge clk); #1 reset = 1'b0;
        acc_m[0] = 0; acc_m[1] = 0;
        dones = 0;
        repeat (3) begin @(negedge clk); if (bus.step_done) dones++; end
        checks++; if (dones != 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses want 0", dones); end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        repeat (4) beat(32'h0001_0000, 32'h0000_0000);
        close_step();
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                e = sb.pop_front(); checks++;
                if (bus.out_a_t !== e.data || bus.out_idx !== e.idx) begin errors++; $display("FAIL rst_clean_data: got idx=%0d a_t=%h want idx=%0d a_t=%h", bus.out_idx, bus.out_a_t, e.idx, e.data); end
            end
            @(posedge clk); #1; cyc++;
        end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rst_clean_timeout: %0d results left want 0", sb.size()); sb.delete(); end
    endtask

    task automatic test_back_to_back();
        int cyc, t1, t2; exp_t e;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) t1 = cycle_cnt;
            else begin
                t2 = cycle_cnt;
                checks++; if (t2 - t1 != 6 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_period: got %0d cycles rdy=%b want 6 1", t2 - t1, bus.in_ready); end
            end
            if (s == 0) repeat (4) beat(32'h0000_C000, 32'h0001_8000);
            else        repeat (4) beat(32'h0000_8000, 32'hFFFF_0000);
            close_step();
            cyc = 0;
            while (sb.size() != 0 && cyc < 20) begin
                @(negedge clk);
                if (bus.out_valid && bus.out_ready) begin
                    e = sb.pop_front(); checks++;
                    if (bus.out_a_t !== e.data || bus.out_idx !== e.idx) begin errors++; $display("FAIL b2b_data: step %0d got idx=%0d a_t=%h want idx=%0d a_t=%h", s, bus.out_idx, bus.out_a_t, e.idx, e.data); end
                end
                @(posedge clk); #1; cyc++;
            end
            checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_timeout: step %0d left %0d want 0", s, sb.size()); sb.delete(); end
        end
    endtask

    initial begin
        acc_m[0] = 0; acc_m[1] = 0; exp_sat = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_saturation();
        test_gapped();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
